shift_add_mult: RTL

//  Sequential unsigned N x N multiplier, radix-2 shift-and-add, one partial product per clock.

---
 rtl/shift_add_mult_pkg.sv | 16 +
 rtl/shift_add_mult_rca_n.sv | 31 +++
 rtl/shift_add_mult.sv | 114 +++++++++++
 3 files changed

// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//  - state_t : FSM state encodings (ST_3 is unreachable and recovers to IDLE)
//  - N_DEFAULT : default operand width
package shift_add_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2,
    ST_3    = 2'd3
  } state_t;

  localparam int N_DEFAULT  = 4;
  localparam int CW_DEFAULT = 3;

endpackage

// File: rtl/shift_add_mult_rca_n.sv
// rca_n: N-bit combinational ripple-carry adder.
// Ports:
//  x, y  in   N   addends
//  cin   in   1   carry into bit 0
//  sum   out  N   x + y + cin, low N bits
//  cout  out  1   carry out of bit N-1
module rca_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  // carry[i] is the carry into bit i; carry[N] is the final carry out.
  logic [N:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign sum[gi]       = x[gi] ^ y[gi] ^ carry[gi];
      assign carry[gi + 1] = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
    end
  endgenerate

  assign cout = carry[N];

endmodule

// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential unsigned N x N multiplier, radix-2 shift-and-add,
// one partial product per clock. A start/ready handshake accepts operands in
// IDLE; the product is written and done pulses for one cycle N edges later.
// Ports:
//  clk      in   1    rising-edge clock
//  rst      in   1    synchronous active-high reset, aborts any operation
//  start    in   1    request, sampled only while ready=1
//  a        in   N    multiplicand, captured on the accepting edge
//  b        in   N    multiplier, captured on the accepting edge
//  ready    out  1    high only in IDLE
//  done     out  1    one-cycle pulse when product is written
//  product  out  2N   last result, held until the next one is written
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

  state_t          state;
  logic [CW-1:0]   count;
  logic [N-1:0]    mcand;
  logic [2*N-1:0]  acc;

  logic [N-1:0]    hi;
  logic [N-1:0]    lo;
  logic [N-1:0]    addend;
  logic [N-1:0]    sum;
  logic            cout;
  logic [2*N-1:0]  acc_shift;

  // Accumulator halves: hi collects partial sums, lo still holds the
  // unconsumed multiplier bits (lo[0] is the bit for this iteration).
  assign hi = acc[2*N-1:N];
  assign lo = acc[N-1:0];

  // Gating the multiplicand by lo[0] makes the adder produce hi+0 when the
  // multiplier bit is clear, so one adder covers both cases.
  assign addend = lo[0] ? mcand : '0;

  rca_n #(
    .N(N)
  ) u_rca (
    .x    (hi),
    .y    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // The carry-out re-enters at the MSB so (2^N-1)^2 fits exactly in 2N bits.
  assign acc_shift = {cout, sum, lo[N-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      count   <= '0;
      mcand   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            acc   <= {{N{1'b0}}, b};
            count <= '0;
            ready <= 1'b0;
            state <= ST_CALC;
          end
        end

        ST_CALC: begin
          acc   <= acc_shift;
          count <= count + CW'(1);
          // The final iteration's result goes straight to product, so the
          // answer is visible on the same edge that raises done.
          if (count == LAST_COUNT) begin
            product <= acc_shift;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end

        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
